// File: rtl/rr_grant_ctrl_pkg.sv
// Shared types and helpers for the round-robin grant controller.
package rr_grant_pkg;

  localparam int STATE_W = 3;

  // Widest channel count the one-hot helper can represent.
  localparam int MAX_CH = 64;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    GRANT = 3'd2,
    REL   = 3'd3
  } state_e;

  // One-hot vector with bit idx set; callers truncate to their channel count.
  function automatic logic [MAX_CH-1:0] onehot(input int unsigned idx);
    return MAX_CH'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_grant_ctrl_if.sv
// Request/grant bundle between the requesters (master) and the controller (slave).
interface rr_grant_ctrl_if
  import rr_grant_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 4,
  parameter int ID_W  = $clog2(N_CH)
) ();

  logic             en;
  logic [N_CH-1:0]  req;
  logic [N_CH-1:0]  done;
  logic [CNT_W-1:0] hold_cycles;
  logic [N_CH-1:0]  grant;
  logic             busy;
  logic [ID_W-1:0]  ch_id;
  logic             timeout;
  logic [STATE_W-1:0] state;

  modport master (
    output en, req, done, hold_cycles,
    input  grant, busy, ch_id, timeout, state
  );

  modport slave (
    input  en, req, done, hold_cycles,
    output grant, busy, ch_id, timeout, state
  );

endinterface

// File: rtl/rr_grant_ctrl_pick.sv
// Rotating priority encoder: first asserted request at or after ptr, wrapping.
module rr_pick #(
  parameter int N_CH = 4,
  parameter int ID_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [ID_W-1:0] idx_o,
  output logic            valid_o
);

  // Scan from the farthest offset down so the offset closest to ptr wins.
  always_comb begin
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] j;
    sum     = '0;
    j       = '0;
    idx_o   = '0;
    valid_o = |req_i;
    for (int k = N_CH - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_i} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(N_CH)) begin
        sum = sum - (ID_W+1)'(N_CH);
      end
      j = sum[ID_W-1:0];
      if (req_i[j]) begin
        idx_o = j;
      end
    end
  end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin request/grant controller with per-grant hold timer and timeout pulse.
module rr_grant_ctrl
  import rr_grant_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 4,
  parameter int ID_W  = $clog2(N_CH)
) (
  input  logic            CK,
  input  logic            RST,
  rr_grant_ctrl_if.slave  bus
);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  ch_id_q, ch_id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]  grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;

  logic [ID_W-1:0]  pick_idx;
  logic             pick_vld;
  logic             done_own;
  logic             expiring;

  rr_pick #(
    .N_CH (N_CH),
    .ID_W (ID_W)
  ) u_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_vld)
  );

  // Only the granted channel's done is honoured; a zero count never expires.
  assign done_own = bus.done[ch_id_q];
  assign expiring = (cnt_q == CNT_W'(1));

  // FSM state plus arbitration context (pointer, granted channel, hold timer).
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      ch_id_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ch_id_q <= ch_id_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; hold_cycles is only sampled in ARB so mid-grant changes are ignored.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ch_id_d   = ch_id_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.en && |bus.req) begin
          state_d = ARB;
        end
      end
      ARB: begin
        if (pick_vld) begin
          state_d = GRANT;
          ch_id_d = pick_idx;
          cnt_d   = bus.hold_cycles;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (done_own) begin
          state_d = REL;
        end else if (expiring) begin
          state_d   = REL;
          timeout_d = 1'b1;
        end
      end
      REL: begin
        ptr_d   = (ch_id_q == ID_W'(N_CH - 1)) ? '0 : ch_id_q + ID_W'(1);
        state_d = (bus.en && |bus.req) ? ARB : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up with state_q.
  always_comb begin
    grant_d = '0;
    busy_d  = (state_d != IDLE);
    if (state_d == GRANT) begin
      grant_d = N_CH'(onehot(32'(ch_id_d)));
    end
  end

  // Output registers; reset drops the grant at once and suppresses any timeout.
  always_ff @(posedge CK) begin
    if (RST) begin
      grant_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.busy    = busy_q;
  assign bus.ch_id   = ch_id_q;
  assign bus.timeout = timeout_q;
  assign bus.state   = state_q;

endmodule
